// File: rtl/pll_phase_ctrl_pkg.sv
// pll_ctrl_pkg: controller state encoding and default timing constants shared by
// the PLL phase controller and its bench.
package pll_ctrl_pkg;
    typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, PH_SETUP, PH_LO, PH_HI} state_t;
    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65535;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_STEP_LO       = 4;
    localparam int DEF_STEP_HI       = 4;
    localparam int SETUP_CYCLES      = 2;
    function automatic int pmax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/pll_phase_ctrl_if.sv
// pll_phase_ctrl_if: phase-step request/response handshake between a requester
// (master) and the PLL phase controller (slave).
interface pll_phase_ctrl_if;
    logic       step_req;
    logic [1:0] step_sel;
    logic       step_dir;
    logic [3:0] step_cnt;
    logic       step_rdy;
    logic       step_ack;
    logic       step_abort;
    modport master (output step_req, step_sel, step_dir, step_cnt,
                    input  step_rdy, step_ack, step_abort);
    modport slave  (input  step_req, step_sel, step_dir, step_cnt,
                    output step_rdy, step_ack, step_abort);
endinterface

// File: rtl/pll_phase_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer bringing an asynchronous level into the clock domain.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_ff1, r_ff2;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ff1 <= 1'b0;
            r_ff2 <= 1'b0;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end
    assign o_q = r_ff2;
endmodule

// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: PLL reset/lock sequencing, system reset release and
// dynamic phase-step pulse generation with lock-loss abort.
module pll_phase_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int STEP_LO       = DEF_STEP_LO,
    parameter int STEP_HI       = DEF_STEP_HI
) (
    input  logic                  i_clkin,
    input  logic                  i_rst_n,
    input  logic                  i_locked,
    pll_phase_ctrl_if.slave       step_if,
    output logic                  o_pll_rst,
    output logic                  o_sys_rst_n,
    output logic [1:0]            o_phasesel,
    output logic                  o_phasedir,
    output logic                  o_phasestep,
    output logic                  o_lock_err
);
    localparam int CMAX = pmax(pmax(pmax(RST_CYCLES, LOCK_TIMEOUT), STABLE_CYCLES),
                               pmax(pmax(STEP_LO, STEP_HI), SETUP_CYCLES));
    localparam int CW   = $clog2(CMAX + 1);

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt, w_inc;
    logic [3:0]    r_rem, w_rem;
    logic [1:0]    r_sel, w_sel;
    logic          r_dir, w_dir, r_ack, w_ack, r_abort, w_abort, r_err, w_err;
    logic          w_locked_s;

    sync_2ff u_sync (
        .i_clk   (i_clkin),
        .i_rst_n (i_rst_n),
        .i_d     (i_locked),
        .o_q     (w_locked_s)
    );

    assign w_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_next  = r_state;
        w_cnt   = r_cnt;
        w_rem   = r_rem;
        w_sel   = r_sel;
        w_dir   = r_dir;
        w_ack   = 1'b0;
        w_abort = 1'b0;
        w_err   = r_err;
        if (r_state inside {PH_SETUP, PH_LO, PH_HI} && !w_locked_s) begin
            w_next  = WAIT_LOCK;
            w_cnt   = '0;
            w_abort = 1'b1;
        end else begin
            case (r_state)
                PLL_RST: begin
                    w_next = (r_cnt >= CW'(RST_CYCLES - 1)) ? WAIT_LOCK : PLL_RST;
                    w_cnt  = (r_cnt >= CW'(RST_CYCLES - 1)) ? '0 : w_inc;
                end
                WAIT_LOCK: begin
                    // the cycle that sees lock already counts toward the stable run
                    if (w_locked_s) begin
                        w_next = STABLE;
                        w_cnt  = CW'(1);
                    end else if (r_cnt >= CW'(LOCK_TIMEOUT - 1)) begin
                        w_next = PLL_RST;
                        w_cnt  = '0;
                        w_err  = 1'b1;
                    end else begin
                        w_cnt = w_inc;
                    end
                end
                STABLE: begin
                    if (!w_locked_s) begin
                        w_cnt = '0;
                    end else if (r_cnt >= CW'(STABLE_CYCLES - 1)) begin
                        w_next = RUN;
                        w_cnt  = '0;
                    end else begin
                        w_cnt = w_inc;
                    end
                end
                RUN: begin
                    if (!w_locked_s) begin
                        w_next = WAIT_LOCK;
                        w_cnt  = '0;
                    end else if (step_if.step_req) begin
                        w_sel  = step_if.step_sel;
                        w_dir  = step_if.step_dir;
                        w_rem  = step_if.step_cnt;
                        w_ack  = (step_if.step_cnt == 4'd0);
                        w_next = (step_if.step_cnt == 4'd0) ? RUN : PH_SETUP;
                        w_cnt  = '0;
                    end
                end
                PH_SETUP: begin
                    w_next = (r_cnt >= CW'(SETUP_CYCLES - 1)) ? PH_LO : PH_SETUP;
                    w_cnt  = (r_cnt >= CW'(SETUP_CYCLES - 1)) ? '0 : w_inc;
                end
                PH_LO: begin
                    w_next = (r_cnt >= CW'(STEP_LO - 1)) ? PH_HI : PH_LO;
                    w_cnt  = (r_cnt >= CW'(STEP_LO - 1)) ? '0 : w_inc;
                end
                PH_HI: begin
                    if (r_cnt >= CW'(STEP_HI - 1)) begin
                        w_cnt  = '0;
                        w_rem  = (r_rem == 4'd0) ? 4'd0 : r_rem - 4'd1;
                        w_next = (r_rem > 4'd1) ? PH_LO : RUN;
                        w_ack  = (r_rem <= 4'd1);
                    end else begin
                        w_cnt = w_inc;
                    end
                end
                default: begin
                    w_next = PLL_RST;
                    w_cnt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clkin or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= PLL_RST;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_sel   <= '0;
            r_dir   <= 1'b0;
            r_ack   <= 1'b0;
            r_abort <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_rem   <= w_rem;
            r_sel   <= w_sel;
            r_dir   <= w_dir;
            r_ack   <= w_ack;
            r_abort <= w_abort;
            r_err   <= w_err;
        end
    end

    assign o_pll_rst          = (r_state == PLL_RST);
    assign o_sys_rst_n        = r_state inside {RUN, PH_SETUP, PH_LO, PH_HI};
    assign o_phasestep        = (r_state != PH_LO);
    assign o_phasesel         = r_sel;
    assign o_phasedir         = r_dir;
    assign o_lock_err         = r_err;
    assign step_if.step_rdy   = (r_state == RUN);
    assign step_if.step_ack   = r_ack;
    assign step_if.step_abort = r_abort;
endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb_pll_phase_ctrl: directed vectors for reset/lock sequencing, phase stepping,
// lock-loss abort and asynchronous reset of the PLL phase controller.
module tb_pll_phase_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       pll_rst, sys_rst_n, phasedir, phasestep, lock_err;
    logic [1:0] phasesel;
    int         n_checks = 0;
    int         n_errors = 0;

    pll_phase_ctrl_if sif ();

    pll_phase_ctrl #(
        .RST_CYCLES    (16),
        .LOCK_TIMEOUT  (100),
        .STABLE_CYCLES (1024),
        .STEP_LO       (4),
        .STEP_HI       (4)
    ) dut (
        .i_clkin     (clk),
        .i_rst_n     (rst_n),
        .i_locked    (locked),
        .step_if     (sif),
        .o_pll_rst   (pll_rst),
        .o_sys_rst_n (sys_rst_n),
        .o_phasesel  (phasesel),
        .o_phasedir  (phasedir),
        .o_phasestep (phasestep),
        .o_lock_err  (lock_err)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start(input logic [1:0] sel, input logic dir, input logic [3:0] cnt);
        sif.step_req = 1'b1;
        sif.step_sel = sel;
        sif.step_dir = dir;
        sif.step_cnt = cnt;
    endtask

    function automatic logic [9:0] outs();
        return {pll_rst, sys_rst_n, phasestep, phasesel, phasedir,
                sif.step_rdy, sif.step_ack, sif.step_abort, lock_err};
    endfunction

    localparam logic [9:0] RST_OUTS = 10'b1_0_1_00_0_0_0_0_0;

    initial begin
        logic [63:0] pat, exp_pat;
        int          acks, ack_at;
        logic        sel_ok, rdy_mid, ps13, seen;
        rst_n        = 1'b0;
        locked       = 1'b0;
        sif.step_req = 1'b0;
        sif.step_sel = 2'd0;
        sif.step_dir = 1'b0;
        sif.step_cnt = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'(RST_OUTS));

        // lock never arrives: timeout, sticky error, PLL reset re-run
        rst_n = 1'b1;
        tick(15);
        chk("pll_rst_c15", 32'(pll_rst), 1);
        tick(1);
        chk("pll_rst_c16", 32'(pll_rst), 0);
        tick(99);
        chk("lock_err_c115", 32'(lock_err), 0);
        tick(1);
        chk("lock_err_c116", 32'(lock_err), 1);
        chk("pll_rst_c116", 32'(pll_rst), 1);
        tick(15);
        chk("pll_rst_c131", 32'(pll_rst), 1);
        tick(1);
        chk("pll_rst_c132", 32'(pll_rst), 0);
        chk("lock_err_sticky", 32'(lock_err), 1);

        // lock at cycle 40, locked_s at 42, system reset released at 42+1024
        do_reset();
        tick(1);
        chk("lock_err_cleared", 32'(lock_err), 0);
        tick(39);
        locked = 1'b1;
        tick(1025);
        chk("sys_rst_n_c1065", 32'(sys_rst_n), 0);
        chk("rdy_c1065", 32'(sif.step_rdy), 0);
        tick(1);
        chk("sys_rst_n_c1066", 32'(sys_rst_n), 1);
        chk("rdy_c1066", 32'(sif.step_rdy), 1);

        // sel=2 dir=1 cnt=3: three 4-cycle low pulses, one ack, ignored mid-sequence request
        tick(2);
        start(2'd2, 1'b1, 4'd3);
        pat = '0; exp_pat = '0; acks = 0; ack_at = 0; sel_ok = 1'b1; rdy_mid = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (i == 1) begin
                sif.step_req = 1'b0;
                sif.step_sel = 2'd1;
                sif.step_dir = 1'b0;
            end
            if (i == 5) start(2'd1, 1'b0, 4'd1);
            if (i == 6) sif.step_req = 1'b0;
            pat[i] = phasestep;
            exp_pat[i] = !(i >= 3 && i <= 22 && ((i - 3) % 8) < 4);
            if (sif.step_ack) begin
                acks++;
                ack_at = i;
            end
            if (i <= 27 && (phasesel != 2'd2 || phasedir != 1'b1)) sel_ok = 1'b0;
            if (i == 10) rdy_mid = sif.step_rdy;
        end
        chk("step_pattern_lo", pat[31:0], exp_pat[31:0]);
        chk("step_pattern_hi", pat[63:32], exp_pat[63:32]);
        chk("step_ack_count", 32'(acks), 1);
        chk("step_ack_cycle", 32'(ack_at), 27);
        chk("sel_dir_stable", 32'(sel_ok), 1);
        chk("rdy_busy", 32'(rdy_mid), 0);

        // zero-length request: ack next cycle, no pulse
        start(2'd3, 1'b1, 4'd0);
        tick(1);
        sif.step_req = 1'b0;
        chk("zero_ack", 32'(sif.step_ack), 1);
        chk("zero_phasestep", 32'(phasestep), 1);
        chk("zero_rdy", 32'(sif.step_rdy), 1);
        tick(1);
        chk("zero_ack_pulse", 32'(sif.step_ack), 0);

        // request held through ack restarts a sequence from RUN
        start(2'd1, 1'b0, 4'd1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            seen = sif.step_ack;
        end
        chk("held_ack1_seen", 32'(seen), 1);
        tick(1);
        chk("held_restart_rdy", 32'(sif.step_rdy), 0);
        chk("held_restart_sel", 32'(phasesel), 1);
        sif.step_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            seen = sif.step_ack;
        end
        chk("held_ack2_seen", 32'(seen), 1);

        // lock lost during the second low pulse
        tick(1);
        start(2'd3, 1'b0, 4'd3);
        acks = 0; ps13 = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick(1);
            if (i == 1) sif.step_req = 1'b0;
            if (i == 11) locked = 1'b0;
            if (i == 13) ps13 = phasestep;
            if (sif.step_ack) acks++;
        end
        chk("abort_pre_ps", 32'(ps13), 0);
        chk("abort_phasestep", 32'(phasestep), 1);
        chk("abort_pulse", 32'(sif.step_abort), 1);
        chk("abort_sys_rst_n", 32'(sys_rst_n), 0);
        chk("abort_no_ack", 32'(acks), 0);
        tick(1);
        chk("abort_pulse_end", 32'(sif.step_abort), 0);
        locked = 1'b1;
        tick(1025);
        chk("relock_sys_rst_n_early", 32'(sys_rst_n), 0);
        tick(1);
        chk("relock_sys_rst_n", 32'(sys_rst_n), 1);

        // asynchronous reset in the middle of a low pulse
        start(2'd2, 1'b1, 4'd2);
        tick(1);
        sif.step_req = 1'b0;
        tick(4);
        chk("mid_seq_phasestep", 32'(phasestep), 0);
        #10;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", 32'(outs()), 32'(RST_OUTS));
        @(negedge clk);
        rst_n = 1'b1;
        tick(15);
        chk("restart_pll_rst_c15", 32'(pll_rst), 1);
        tick(1);
        chk("restart_pll_rst_c16", 32'(pll_rst), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
